id_ex_forward_unit: RTL and testbench
=====================================

ID_EX_FORWARD_UNIT -- requirements
Module: id_ex_forward_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath operand width.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  decode stage holds a valid instruction.
REQ-007 id_rs1, id_rs2  in  REG_W  decode source indices.
REQ-008 id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
REQ-009 id_rd  in  REG_W  decode destination index.
REQ-010 id_reg_write, id_mem_read  in  1  decode control bits.
REQ-011 exmem_rd, memwb_rd  in  REG_W  destination indices in MEM and WB stages.
REQ-012 exmem_reg_write, memwb_reg_write  in  1  write enables in MEM and WB stages.
REQ-013 flush  in  1  taken branch/jump; kill the decode instruction.
REQ-014 stall_out  out  1  freeze PC and IF/ID register this cycle.
REQ-015 ex_valid, ex_reg_write, ex_mem_read  out  1  registered EX-stage controls.
REQ-016 ex_rs1, ex_rs2, ex_rd  out  REG_W  registered EX-stage indices.
REQ-017 ex_rs1_data, ex_rs2_data  out  DATA_W  registered operands; in1 of the EX 3-input muxes.
REQ-018 ex_fwd_a, ex_fwd_b  out  2  EX 3-input mux selects: 0 = register data, 1 = EX/MEM result, 2 = MEM/WB result.
REQ-019 stall_cnt  out  CNT_W  count of load-use stall cycles.

Function
REQ-020 On each clock edge with stall_out=0 and flush=0, the ID/EX register SHALL load all id_* fields; ex_valid SHALL take id_valid.
REQ-021 load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2); stall_out SHALL equal load_use & ~flush, combinationally.
REQ-022 On a stall cycle, the ID/EX register SHALL load a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, indices 0, data 0.
REQ-023 On flush=1, the ID/EX register SHALL load a bubble; flush SHALL take priority over stall.
REQ-024 A load-use hazard SHALL cost exactly one bubble; the dependent instruction enters EX on the following edge.
REQ-025 ex_fwd_a SHALL be 1 if exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs1; else 2 if memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs1; else 0.
REQ-026 ex_fwd_b SHALL follow REQ-025 using ex_rs2.
REQ-027 EX/MEM SHALL win over MEM/WB when both match; register 0 SHALL never forward.
REQ-028 ex_fwd_a and ex_fwd_b SHALL be combinational from the current-cycle registered/input values; the value 3 SHALL never be driven.
REQ-029 When ex_valid=0, ex_fwd_a and ex_fwd_b SHALL be 0.
REQ-030 stall_cnt SHALL increment by 1 on every edge where stall_out=1 and SHALL saturate at all-ones.

Reset
REQ-031 While rst_n=0, all ID/EX fields and stall_cnt SHALL be 0 immediately (asynchronous).
REQ-032 Consequently stall_out=0 and ex_fwd_a=ex_fwd_b=0 during reset.
REQ-033 Reset asserted mid-stall SHALL clear the stall; after release, capture SHALL resume on the first edge.

Structure
REQ-034 The forwarding select encodings (FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2) SHALL live in the shared pipeline package, used by this block and the datapath.
REQ-035 One sub-module SHALL be natural: fwd_sel (purely combinational comparator, instantiated twice, for A and B).

Verification
REQ-036 Back-to-back ALU: EX/MEM rd=5 write=1, EX rs1=5 -> ex_fwd_a=1, ex_fwd_b=0.
REQ-037 Double hazard: exmem_rd=memwb_rd=7, both writing, ex_rs2=7 -> ex_fwd_b=1; only memwb matches -> ex_fwd_b=2.
REQ-038 Load-use: EX load rd=3, ID rs1=3 -> stall_out=1 for one cycle, bubble in EX, stall_cnt 0->1; next cycle, dependent in EX with memwb_rd=3 -> ex_fwd_a=2.
REQ-039 Flush and stall in the same cycle -> stall_out=0, bubble loaded, stall_cnt unchanged.
REQ-040 Register 0: exmem_rd=0, write=1, ex_rs1=0 -> ex_fwd_a=0; EX load rd=0 -> no stall.
REQ-041 rst_n low mid-stall -> all outputs 0 asynchronously; stall_cnt preloaded to all-ones then stall -> stays all-ones.

Source files
------------

// File: rtl/id_ex_forward_unit_pkg.sv
// Shared pipeline definitions: EX operand-mux select encodings used by the
// forwarding unit and by the EX datapath that consumes its selects.
package id_ex_forward_unit_pkg;

   localparam int FWD_SEL_W = 2;

   typedef enum logic [FWD_SEL_W-1:0] {
      FWD_REG   = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   // The younger producer (EX/MEM) holds the newer value, so it wins.
   function automatic fwd_sel_e fwd_pick(input logic hit_exmem, input logic hit_memwb);
      if (hit_exmem) return FWD_EXMEM;
      if (hit_memwb) return FWD_MEMWB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/id_ex_forward_unit_fwd_sel.sv
// Forwarding comparator for one EX source operand; purely combinational.
module id_ex_forward_unit_fwd_sel
   import id_ex_forward_unit_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             ex_valid_i,
   input  logic [REG_W-1:0] ex_rs_i,
   input  logic [REG_W-1:0] exmem_rd_i,
   input  logic             exmem_reg_write_i,
   input  logic [REG_W-1:0] memwb_rd_i,
   input  logic             memwb_reg_write_i,
   output fwd_sel_e         sel_o
);

   logic hit_exmem;
   logic hit_memwb;

   // x0 is hardwired zero, so a write to it must never be forwarded.
   assign hit_exmem = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs_i);
   assign hit_memwb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs_i);

   assign sel_o = ex_valid_i ? fwd_pick(hit_exmem, hit_memwb) : FWD_REG;

endmodule

// File: rtl/id_ex_forward_unit.sv
// ID/EX pipeline register with load-use stall detection, bubble/flush
// insertion, EX operand-forwarding selects and a saturating stall counter.
module id_ex_forward_unit
   import id_ex_forward_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic              exmem_reg_write,
   input  logic              memwb_reg_write,
   input  logic              flush,
   output logic              stall_out,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [REG_W-1:0]  ex_rs1,
   output logic [REG_W-1:0]  ex_rs2,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_rs1_data,
   output logic [DATA_W-1:0] ex_rs2_data,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic [CNT_W-1:0]  stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic              valid_q,  valid_d;
   logic              rw_q,     rw_d;
   logic              mr_q,     mr_d;
   logic [REG_W-1:0]  rs1_q,    rs1_d;
   logic [REG_W-1:0]  rs2_q,    rs2_d;
   logic [REG_W-1:0]  rd_q,     rd_d;
   logic [DATA_W-1:0] d1_q,     d1_d;
   logic [DATA_W-1:0] d2_q,     d2_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic              load_use;
   fwd_sel_e          sel_a;
   fwd_sel_e          sel_b;

   // The loaded value only exists after MEM, so a dependent in ID must wait.
   assign load_use = valid_q && mr_q && (rd_q != '0) && id_valid &&
                     ((rd_q == id_rs1) || (rd_q == id_rs2));
   assign stall_out = load_use && !flush;

   always_comb begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      if (!flush && !stall_out) begin
         valid_d = id_valid;
         rw_d    = id_reg_write;
         mr_d    = id_mem_read;
         rs1_d   = id_rs1;
         rs2_d   = id_rs2;
         rd_d    = id_rd;
         d1_d    = id_rs1_data;
         d2_d    = id_rs2_data;
      end
      cnt_d = stall_out ? sat_inc(cnt_q) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         cnt_q   <= cnt_d;
      end
   end

   id_ex_forward_unit_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
      .ex_valid_i        (valid_q),
      .ex_rs_i           (rs1_q),
      .exmem_rd_i        (exmem_rd),
      .exmem_reg_write_i (exmem_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_reg_write_i (memwb_reg_write),
      .sel_o             (sel_a)
   );

   id_ex_forward_unit_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
      .ex_valid_i        (valid_q),
      .ex_rs_i           (rs2_q),
      .exmem_rd_i        (exmem_rd),
      .exmem_reg_write_i (exmem_reg_write),
      .memwb_rd_i        (memwb_rd),
      .memwb_reg_write_i (memwb_reg_write),
      .sel_o             (sel_b)
   );

   assign ex_valid     = valid_q;
   assign ex_reg_write = rw_q;
   assign ex_mem_read  = mr_q;
   assign ex_rs1       = rs1_q;
   assign ex_rs2       = rs2_q;
   assign ex_rd        = rd_q;
   assign ex_rs1_data  = d1_q;
   assign ex_rs2_data  = d2_q;
   assign ex_fwd_a     = sel_a;
   assign ex_fwd_b     = sel_b;
   assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_forward_unit.sv
// Bench for id_ex_forward_unit: directed hazard scenarios followed by random
// traffic, all checked against a rule-level model of the EX stage.
module tb_id_ex_forward_unit;

   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = 7;

   typedef struct packed {
      logic              valid;
      logic              rw;
      logic              mr;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
   } ex_t;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
   logic [DATA_W-1:0] id_rs1_data, id_rs2_data;
   logic              id_reg_write, id_mem_read;
   logic [REG_W-1:0]  exmem_rd, memwb_rd;
   logic              exmem_reg_write, memwb_reg_write;
   logic              flush;
   logic              stall_out;
   logic              ex_valid, ex_reg_write, ex_mem_read;
   logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
   logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data;
   logic [1:0]        ex_fwd_a, ex_fwd_b;
   logic [CNT_W-1:0]  stall_cnt;

   ex_t m;
   int  m_cnt;
   int  n_total;
   int  n_pass;
   int  n_fail;

   id_ex_forward_unit #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_data     (id_rs1_data),
      .id_rs2_data     (id_rs2_data),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .exmem_rd        (exmem_rd),
      .memwb_rd        (memwb_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_reg_write (memwb_reg_write),
      .flush           (flush),
      .stall_out       (stall_out),
      .ex_valid        (ex_valid),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read),
      .ex_rs1          (ex_rs1),
      .ex_rs2          (ex_rs2),
      .ex_rd           (ex_rd),
      .ex_rs1_data     (ex_rs1_data),
      .ex_rs2_data     (ex_rs2_data),
      .ex_fwd_a        (ex_fwd_a),
      .ex_fwd_b        (ex_fwd_b),
      .stall_cnt       (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // A load in EX whose result a valid decode instruction reads must wait.
   function automatic logic model_stall();
      logic reads;
      reads = (m.rd == id_rs1) || (m.rd == id_rs2);
      return m.valid && m.mr && (m.rd != 0) && id_valid && reads && !flush;
   endfunction

   function automatic logic [31:0] model_fwd(input logic [REG_W-1:0] rs);
      if (!m.valid) return 0;
      if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return 1;
      if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return 2;
      return 0;
   endfunction

   task automatic chk_ex(input string tag);
      chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.valid));
      chk({tag, ".ex_rw"},    32'(ex_reg_write), 32'(m.rw));
      chk({tag, ".ex_mr"},    32'(ex_mem_read), 32'(m.mr));
      chk({tag, ".ex_rs1"},   32'(ex_rs1), 32'(m.rs1));
      chk({tag, ".ex_rs2"},   32'(ex_rs2), 32'(m.rs2));
      chk({tag, ".ex_rd"},    32'(ex_rd), 32'(m.rd));
      chk({tag, ".ex_d1"},    ex_rs1_data, m.d1);
      chk({tag, ".ex_d2"},    ex_rs2_data, m.d2);
      chk({tag, ".cnt"},      32'(stall_cnt), 32'(m_cnt));
   endtask

   // Entered just after a falling edge with inputs already driven.
   task automatic cycle(input string tag);
      logic st;
      ex_t  nxt;
      #1;
      st = model_stall();
      chk({tag, ".stall"}, 32'(stall_out), 32'(st));
      chk({tag, ".fwd_a"}, 32'(ex_fwd_a), model_fwd(m.rs1));
      chk({tag, ".fwd_b"}, 32'(ex_fwd_b), model_fwd(m.rs2));
      nxt = '0;
      if (!flush && !st) begin
         nxt.valid = id_valid;
         nxt.rw    = id_reg_write;
         nxt.mr    = id_mem_read;
         nxt.rs1   = id_rs1;
         nxt.rs2   = id_rs2;
         nxt.rd    = id_rd;
         nxt.d1    = id_rs1_data;
         nxt.d2    = id_rs2_data;
      end
      @(posedge clk);
      m = nxt;
      if (st && m_cnt < CNT_MAX) m_cnt++;
      #1;
      chk_ex(tag);
      @(negedge clk);
   endtask

   task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                         input logic rw, input logic mr);
      id_valid     = v;
      id_rs1       = REG_W'(rs1);
      id_rs2       = REG_W'(rs2);
      id_rd        = REG_W'(rd);
      id_reg_write = rw;
      id_mem_read  = mr;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
   endtask

   task automatic set_wb(input int xr, input logic xw, input int wr, input logic ww);
      exmem_rd        = REG_W'(xr);
      exmem_reg_write = xw;
      memwb_rd        = REG_W'(wr);
      memwb_reg_write = ww;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stall"}, 32'(stall_out), 0);
      chk({tag, ".fwd_a"}, 32'(ex_fwd_a), 0);
      chk({tag, ".fwd_b"}, 32'(ex_fwd_b), 0);
      chk({tag, ".valid"}, 32'(ex_valid), 0);
      chk({tag, ".rw"},    32'(ex_reg_write), 0);
      chk({tag, ".mr"},    32'(ex_mem_read), 0);
      chk({tag, ".rs1"},   32'(ex_rs1), 0);
      chk({tag, ".rs2"},   32'(ex_rs2), 0);
      chk({tag, ".rd"},    32'(ex_rd), 0);
      chk({tag, ".d1"},    ex_rs1_data, 0);
      chk({tag, ".d2"},    ex_rs2_data, 0);
      chk({tag, ".cnt"},   32'(stall_cnt), 0);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      n_fail  = 0;
      m       = '0;
      m_cnt   = 0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      set_id(1'b1, 1, 2, 3, 1'b1, 1'b0);
      set_wb(1, 1'b1, 2, 1'b1);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
      set_wb(0, 1'b0, 0, 1'b0);

      // Back-to-back ALU dependency forwarded from EX/MEM
      set_id(1'b1, 5, 6, 1, 1'b1, 1'b0);
      cycle("b2b_ld");
      set_wb(5, 1'b1, 0, 1'b0);
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("b2b.fwd_a", 32'(ex_fwd_a), 1);
      chk("b2b.fwd_b", 32'(ex_fwd_b), 0);
      cycle("b2b");

      // Both later stages write the same register
      set_wb(0, 1'b0, 0, 1'b0);
      set_id(1'b1, 1, 7, 2, 1'b1, 1'b0);
      cycle("dh_ld");
      set_wb(7, 1'b1, 7, 1'b1);
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("dh.both.fwd_b", 32'(ex_fwd_b), 1);
      chk("dh.both.fwd_a", 32'(ex_fwd_a), 0);
      set_wb(9, 1'b1, 7, 1'b1);
      #1;
      chk("dh.memwb.fwd_b", 32'(ex_fwd_b), 2);
      cycle("dh");

      // Load-use: one bubble, then forward from MEM/WB
      set_wb(0, 1'b0, 0, 1'b0);
      set_id(1'b1, 0, 0, 3, 1'b1, 1'b1);
      cycle("lu_ld");
      set_id(1'b1, 3, 4, 5, 1'b1, 1'b0);
      #1;
      chk("lu.stall", 32'(stall_out), 1);
      chk("lu.cnt0", 32'(stall_cnt), 0);
      cycle("lu_stall");
      chk("lu.bubble", 32'(ex_valid), 0);
      chk("lu.cnt1", 32'(stall_cnt), 1);
      chk("lu.released", 32'(stall_out), 0);
      cycle("lu_go");
      chk("lu.dep_in_ex", 32'(ex_rs1), 3);
      set_wb(0, 1'b0, 3, 1'b1);
      set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      chk("lu.fwd_a", 32'(ex_fwd_a), 2);
      cycle("lu_fwd");

      // Flush coinciding with a load-use hazard
      set_wb(0, 1'b0, 0, 1'b0);
      set_id(1'b1, 0, 0, 3, 1'b1, 1'b1);
      cycle("fs_ld");
      set_id(1'b1, 3, 0, 5, 1'b1, 1'b0);
      flush = 1'b1;
      #1;
      chk("fs.stall", 32'(stall_out), 0);
      cycle("fs");
      chk("fs.bubble", 32'(ex_valid), 0);
      chk("fs.cnt", 32'(stall_cnt), 1);
      flush = 1'b0;

      // Register 0 never forwards and never stalls
      set_id(1'b1, 0, 2, 0, 1'b1, 1'b1);
      cycle("r0_ld");
      set_wb(0, 1'b1, 0, 1'b1);
      set_id(1'b1, 0, 0, 6, 1'b1, 1'b0);
      #1;
      chk("r0.fwd_a", 32'(ex_fwd_a), 0);
      chk("r0.stall", 32'(stall_out), 0);
      cycle("r0");
      set_wb(0, 1'b0, 0, 1'b0);

      // Asynchronous reset in the middle of a stall
      set_id(1'b1, 0, 0, 3, 1'b1, 1'b1);
      cycle("rs_ld");
      set_id(1'b1, 3, 0, 5, 1'b1, 1'b0);
      #1;
      chk("rs.stall_pre", 32'(stall_out), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rs_async");
      m     = '0;
      m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle("rs_rel");
      chk("rs.resume", 32'(ex_valid), 1);

      // Repeated self-dependent loads drive the counter into saturation
      set_id(1'b1, 3, 0, 3, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle("sat");
      chk("sat.cnt", 32'(stall_cnt), CNT_MAX);

      for (int i = 0; i < 300; i++) begin
         set_id(1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         set_wb($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         flush = ($urandom_range(0, 9) == 0);
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
